// File: rtl/ssd_scan_decoder.sv
// Receive-side decoder for a multiplexed seven-segment display: samples each
// scanned digit once stable and publishes complete frames atomically.
// Optional statistics outputs (frame_changed, frame_count) via SSD_DECODE_STATS_EN.
module ssd_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 16,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   ssdAnode,
  input  logic [6:0]              ssdCathode,
  input  logic                    decimalPoint,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   invalid_mask,
  output logic                    frame_valid
`ifdef SSD_DECODE_STATS_EN
  ,
  output logic                    frame_changed,
  output logic [15:0]             frame_count
`endif
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] LSB_ONE = NUM_DIGITS'(1);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_SEL, SETTLE, CAPTURE, HOLD} state_t;

  state_t                  r_state, w_next;
  logic [NUM_DIGITS-1:0]   r_an_in;
  logic [6:0]              r_cath_in;
  logic                    r_dp_in;
  logic [NUM_DIGITS-1:0]   w_an;
  logic [6:0]              w_cath;
  logic                    w_dp;
  logic [NUM_DIGITS-1:0]   r_lat_an;
  logic [6:0]              r_lat_cath;
  logic                    r_lat_dp;
  logic [IW-1:0]           r_idx, w_idx;
  logic [7:0]              r_cnt;
  logic                    w_onehot, w_changed, w_latch, w_capture;
  logic [NUM_DIGITS-1:0]   r_seen, w_idx_bit;
  logic [4*NUM_DIGITS-1:0] r_work_dig;
  logic [NUM_DIGITS-1:0]   r_work_dp, r_work_inv;
  logic                    r_copy;
  logic [4:0]              w_dec;

  // Returns {invalid, nibble}; blank and unknown patterns read as nibble 0.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'h3F: return 5'h00;
      7'h06: return 5'h01;
      7'h5B: return 5'h02;
      7'h4F: return 5'h03;
      7'h66: return 5'h04;
      7'h6D: return 5'h05;
      7'h7D: return 5'h06;
      7'h07: return 5'h07;
      7'h7F: return 5'h08;
      7'h6F: return 5'h09;
      7'h77: return 5'h0A;
      7'h7C: return 5'h0B;
      7'h39: return 5'h0C;
      7'h5E: return 5'h0D;
      7'h79: return 5'h0E;
      7'h71: return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an_in   <= '0;
      r_cath_in <= '0;
      r_dp_in   <= 1'b0;
    end else begin
      r_an_in   <= ssdAnode;
      r_cath_in <= ssdCathode;
      r_dp_in   <= decimalPoint;
    end
  end

  assign w_an   = (ACTIVE_LOW != 0) ? ~r_an_in : r_an_in;
  assign w_cath = (ACTIVE_LOW != 0) ? ~r_cath_in : r_cath_in;
  assign w_dp   = (ACTIVE_LOW != 0) ? ~r_dp_in : r_dp_in;

  assign w_onehot  = (w_an != '0) && ((w_an & (w_an - LSB_ONE)) == '0);
  assign w_changed = (w_an != r_lat_an) || (w_cath != r_lat_cath) || (w_dp != r_lat_dp);
  assign w_idx_bit = LSB_ONE << r_idx;
  assign w_dec     = decode_seg(r_lat_cath);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_an[i]) w_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= WAIT_SEL;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      WAIT_SEL: begin
        if (w_onehot) begin
          w_next  = SETTLE;
          w_latch = 1'b1;
        end
      end
      SETTLE: begin
        if (w_changed) begin
          if (w_onehot) w_latch = 1'b1;
          else          w_next  = WAIT_SEL;
        end else if (r_cnt >= CNT_LAST) begin
          w_next = CAPTURE;
        end
      end
      CAPTURE: begin
        w_capture = 1'b1;
        w_next    = HOLD;
      end
      HOLD: begin
        if (w_changed) begin
          if (w_onehot) begin
            w_next  = SETTLE;
            w_latch = 1'b1;
          end else begin
            w_next = WAIT_SEL;
          end
        end
      end
      default: w_next = WAIT_SEL;
    endcase
  end

  // Latched copy of the lines being settled; the change detector compares against it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lat_an   <= '0;
      r_lat_cath <= '0;
      r_lat_dp   <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
    end else if (w_latch) begin
      r_lat_an   <= w_an;
      r_lat_cath <= w_cath;
      r_lat_dp   <= w_dp;
      r_idx      <= w_idx;
      r_cnt      <= '0;
    end else if (r_state == SETTLE && r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work_dig   <= '0;
      r_work_dp    <= '0;
      r_work_inv   <= '0;
      r_seen       <= '0;
      r_copy       <= 1'b0;
      digits       <= '0;
      dp_mask      <= '0;
      invalid_mask <= '0;
      frame_valid  <= 1'b0;
    end else begin
      r_copy      <= 1'b0;
      frame_valid <= 1'b0;
      if (w_capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (IW'(i) == r_idx) begin
            r_work_dig[4*i +: 4] <= w_dec[3:0];
            r_work_dp[i]         <= r_lat_dp;
            r_work_inv[i]        <= w_dec[4];
          end
        end
        r_seen <= r_seen | w_idx_bit;
        if ((r_seen | w_idx_bit) == '1) r_copy <= 1'b1;
      end
      if (r_copy) begin
        digits       <= r_work_dig;
        dp_mask      <= r_work_dp;
        invalid_mask <= r_work_inv;
        frame_valid  <= 1'b1;
        r_seen       <= '0;
      end
    end
  end

`ifdef SSD_DECODE_STATS_EN
  logic r_first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first       <= 1'b1;
      frame_changed <= 1'b0;
      frame_count   <= '0;
    end else begin
      frame_changed <= 1'b0;
      if (r_copy) begin
        r_first       <= 1'b0;
        frame_changed <= r_first ||
                         ({r_work_dig, r_work_dp, r_work_inv} != {digits, dp_mask, invalid_mask});
        frame_count   <= frame_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed scans plus randomized frames checked
// against a table-driven frame model.
module tb_ssd_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ssdAnode;
  logic [6:0]  ssdCathode;
  logic        decimalPoint;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic [7:0]  invalid_mask;
  logic        frame_valid;
`ifdef SSD_DECODE_STATS_EN
  logic        frame_changed;
  logic [15:0] frame_count;
`endif

  ssd_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(16), .ACTIVE_LOW(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .ssdAnode     (ssdAnode),
    .ssdCathode   (ssdCathode),
    .decimalPoint (decimalPoint),
    .digits       (digits),
    .dp_mask      (dp_mask),
    .invalid_mask (invalid_mask),
    .frame_valid  (frame_valid)
`ifdef SSD_DECODE_STATS_EN
    ,
    .frame_changed(frame_changed),
    .frame_count  (frame_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_frames = 0;
  int exp_frames = 0;
  logic        snap_changed = 1'b0;
  logic [15:0] snap_count = '0;

  // Seven-segment glyphs (active-high, gfedcba) for hex values 0..F.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [31:0] m_dig  = '0;
  logic [7:0]  m_dp   = '0;
  logic [7:0]  m_inv  = '0;
  logic [7:0]  m_seen = '0;
  logic [47:0] m_prev = '0;
  logic        m_first = 1'b1;
  logic [15:0] m_count = '0;
  logic [3:0]  chg_hist = '0;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      n_frames = n_frames + 1;
`ifdef SSD_DECODE_STATS_EN
      snap_changed = frame_changed;
      snap_count   = frame_count;
`endif
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] an_ah, input logic [6:0] seg_ah, input logic dp_ah,
                       input int cycles);
    @(negedge clk);
    ssdAnode     = ~an_ah;
    ssdCathode   = ~seg_ah;
    decimalPoint = ~dp_ah;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic check_frame();
    logic [47:0] cur;
    chk("frame_count_seen", n_frames, exp_frames);
    chk("digits", digits, m_dig);
    chk("dp_mask", dp_mask, m_dp);
    chk("invalid_mask", invalid_mask, m_inv);
    chk("frame_valid_idle", frame_valid, 1'b0);
    cur = {m_dig, m_dp, m_inv};
`ifdef SSD_DECODE_STATS_EN
    m_count = m_count + 16'd1;
    chk("frame_changed", snap_changed, m_first || (cur != m_prev));
    chk("frame_count", snap_count, m_count);
    chg_hist = {chg_hist[2:0], snap_changed};
`endif
    m_prev  = cur;
    m_first = 1'b0;
  endtask

  // Scan one digit long enough to be sampled; the model decodes by table lookup.
  task automatic scan(input int k, input logic [6:0] seg, input logic dp, input int cycles);
    logic found;
    found = 1'b0;
    drive(8'(1) << k, seg, dp, cycles);
    m_dig[4*k +: 4] = 4'h0;
    for (int v = 0; v < 16; v++) begin
      if (seg_tab[v] == seg) begin
        m_dig[4*k +: 4] = 4'(v);
        found = 1'b1;
      end
    end
    m_inv[k]  = ~found;
    m_dp[k]   = dp;
    m_seen[k] = 1'b1;
    if (m_seen == 8'hFF) begin
      m_seen = '0;
      exp_frames++;
      check_frame();
    end else begin
      chk("no_early_frame", n_frames, exp_frames);
    end
  endtask

  task automatic do_reset();
    drive(8'h00, 7'h00, 1'b0, 4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_digits", digits, 32'h0);
    chk("rst_dp", dp_mask, 8'h0);
    chk("rst_inv", invalid_mask, 8'h0);
    chk("rst_fv", frame_valid, 1'b0);
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    m_seen  = '0;
    m_first = 1'b1;
    m_count = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [6:0] seg;
    int j;
    reset        = 1'b1;
    ssdAnode     = 8'hFF;
    ssdCathode   = 7'h7F;
    decimalPoint = 1'b1;
    repeat (3) @(negedge clk);
    chk("init_digits", digits, 32'h0);
    chk("init_fv", frame_valid, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // "01234567", one digit per anode.
    for (int k = 0; k < 8; k++) scan(k, seg_tab[k], 1'b0, 100);
    chk("plan_01234567", digits, 32'h76543210);

    // "0.250" on digits 3..0, digits 7..4 blank.
    for (int k = 4; k < 8; k++) scan(k, 7'h00, 1'b0, 40);
    scan(3, seg_tab[0], 1'b1, 40);
    scan(2, seg_tab[2], 1'b0, 40);
    scan(1, seg_tab[5], 1'b0, 40);
    scan(0, seg_tab[0], 1'b0, 40);
    chk("plan_0250_lo", digits[15:0], 16'h0250);
    chk("plan_0250_dp", dp_mask, 8'h08);
    chk("plan_0250_inv", invalid_mask, 8'hF0);

    // Cathode glitching every 10 cycles must never be sampled.
    for (int k = 0; k < 7; k++) scan(k, seg_tab[k + 8], 1'b0, 30);
    for (int g = 0; g < 10; g++) drive(8'h80, seg_tab[g % 2 + 1], 1'b0, 10);
    chk("glitch_no_frame", n_frames, exp_frames);
    scan(7, seg_tab[9], 1'b0, 40);

    // Two anodes active together: nothing captured during that window.
    scan(0, seg_tab[1], 1'b0, 30);
    scan(1, seg_tab[3], 1'b0, 30);
    scan(2, seg_tab[5], 1'b0, 30);
    scan(3, seg_tab[7], 1'b0, 30);
    scan(6, seg_tab[11], 1'b0, 30);
    scan(7, seg_tab[13], 1'b0, 30);
    drive(8'h30, seg_tab[15], 1'b0, 50);
    chk("two_anode_no_frame", n_frames, exp_frames);
    scan(4, seg_tab[14], 1'b1, 30);
    scan(5, seg_tab[12], 1'b0, 30);

    // Randomized frames, with occasional recapture of an earlier digit.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 8; k++) begin
        if (k > 0 && $urandom_range(0, 3) == 0) begin
          j = $urandom_range(0, k - 1);
          scan(j, seg_tab[$urandom_range(0, 15)], 1'($urandom_range(0, 1)),
               $urandom_range(25, 60));
        end
        if ($urandom_range(0, 99) < 20) seg = 7'($urandom_range(0, 127));
        else                            seg = seg_tab[$urandom_range(0, 15)];
        scan(k, seg, 1'($urandom_range(0, 1)), $urandom_range(25, 60));
      end
    end

    // Reset after five digits discards the partial frame.
    for (int k = 0; k < 5; k++) scan(k, seg_tab[k + 3], 1'b0, 30);
    do_reset();
    chk("post_rst_digits", digits, 32'h0);
    for (int k = 5; k < 8; k++) scan(k, seg_tab[k], 1'b0, 30);
    chk("post_rst_partial", n_frames, exp_frames);
    for (int k = 0; k < 5; k++) scan(k, seg_tab[k], 1'b0, 30);

    // Three identical frames then digit 0 changed 3 -> 4, straight after reset.
    do_reset();
    chg_hist = '0;
    for (int f = 0; f < 4; f++) begin
      scan(0, (f == 3) ? seg_tab[4] : seg_tab[3], 1'b0, 30);
      for (int k = 1; k < 8; k++) scan(k, seg_tab[k + 8], 1'b0, 30);
    end
`ifdef SSD_DECODE_STATS_EN
    chk("changed_pattern", chg_hist, 4'b1001);
`endif
    chk("final_frames", n_frames, exp_frames);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
